// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 sequential multiplier.
package fp16_pkg;

   localparam int unsigned BIAS    = 15;
   localparam logic [4:0]  EXP_INF = 5'h1F;
   localparam logic [15:0] QNAN    = 16'h7E00;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      NORM,
      PACK,
      DONE
   } state_t;

   typedef struct packed {
      logic        sign;
      logic [4:0]  exp;
      logic [10:0] mant;
      logic        is_zero;
      logic        is_inf;
      logic        is_nan;
   } unpacked_t;

endpackage

// File: rtl/fp16_unpack.sv
// Classifies an FP16 operand and expands denormals to exponent 1 with hidden bit 0.
import fp16_pkg::*;

module fp16_unpack (
   input  logic [15:0] value,
   output unpacked_t   fields
);

   logic [4:0] exp_field;
   logic [9:0] frac_field;

   always_comb begin
      exp_field      = value[14:10];
      frac_field     = value[9:0];
      fields.sign    = value[15];
      fields.exp     = (exp_field == 5'd0) ? 5'd1 : exp_field;
      fields.mant    = {(exp_field != 5'd0), frac_field};
      fields.is_nan  = (exp_field == EXP_INF) && (frac_field != 10'd0);
      fields.is_inf  = (exp_field == EXP_INF) && (frac_field == 10'd0);
      fields.is_zero = (exp_field == 5'd0) && (frac_field == 10'd0);
   end

endmodule

// File: rtl/fp16_seq_multiplier.sv
// Sequential FP16 multiplier: 11-cycle shift-add mantissa product, normalise, pack.
// Define FP16_MUL_RNE_EN for round-to-nearest-even; default truncates.
import fp16_pkg::*;

module fp16_seq_multiplier (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out
);

   state_t             state, next_state;
   unpacked_t          ua, ub;
   logic               sign, nan_flag, inf_flag, zero_flag, special;
   logic               nan_in, inf_in, zero_in, special_in;
   logic [10:0]        mcand, mplier;
   logic [21:0]        prod;
   logic [3:0]         count;
   logic signed [6:0]  exponent;
   logic [6:0]         exp_sum;
   logic [14:0]        field;
   logic [4:0]         exp_bits;
   logic [15:0]        result;

   fp16_unpack u_unpack_a (.value(a), .fields(ua));
   fp16_unpack u_unpack_b (.value(b), .fields(ub));

   always_comb begin
      nan_in     = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf);
      inf_in     = ua.is_inf || ub.is_inf;
      zero_in    = ua.is_zero || ub.is_zero;
      special_in = nan_in || inf_in || zero_in;
      exp_sum    = 7'(ua.exp) + 7'(ub.exp) - 7'(BIAS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Specials pass through NORM untouched, giving them a fixed two-cycle latency.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = special_in ? NORM : MULT;
         end
         MULT: if (count == 4'd10) next_state = NORM;
         NORM: if (special || prod[21] || prod[20] || exponent <= 7'sd1) next_state = PACK;
         PACK: next_state = DONE;
         DONE: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      exp_bits = (exponent == 7'sd1 && !prod[20]) ? 5'd0 : exponent[4:0];
      field    = {exp_bits, prod[19:10]};
`ifdef FP16_MUL_RNE_EN
      // A carry out of exponent 30 lands exactly on the Inf encoding.
      field    = field + 15'(prod[9] & ((|prod[8:0]) | prod[10]));
`endif
      if (nan_flag)                result = QNAN;
      else if (inf_flag)           result = {sign, EXP_INF, 10'h0};
      else if (zero_flag)          result = {sign, 15'h0};
      else if (exponent >= 7'sd31) result = {sign, EXP_INF, 10'h0};
      else if (exponent < 7'sd1)   result = {sign, 15'h0};
      else                         result = {sign, field};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign      <= 1'b0;
         nan_flag  <= 1'b0;
         inf_flag  <= 1'b0;
         zero_flag <= 1'b0;
         special   <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         count     <= '0;
         exponent  <= '0;
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sign      <= ua.sign ^ ub.sign;
               mcand     <= ua.mant;
               mplier    <= ub.mant;
               exponent  <= exp_sum;
               nan_flag  <= nan_in;
               inf_flag  <= inf_in;
               zero_flag <= zero_in;
               special   <= special_in;
               prod      <= '0;
               count     <= '0;
            end
            MULT: begin
               if (mplier[count]) prod <= prod + (22'(mcand) << count);
               count <= count + 4'd1;
            end
            NORM: if (!special) begin
               if (prod[21]) begin
                  prod     <= prod >> 1;
                  exponent <= exponent + 7'sd1;
               end else if (!prod[20] && exponent > 7'sd1) begin
                  prod     <= prod << 1;
                  exponent <= exponent - 7'sd1;
               end
            end
            PACK: begin
               out       <= result;
               out_valid <= 1'b1;
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
